// File: rtl/exec_ctrl_pkg.sv
// Shared opcode constants, control-bit positions and issue-FSM states
// for the execute-stage issue controller.
package exec_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_INC = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b110;

  localparam int BR_COND = 3;
  localparam int BR_JMP  = 7;

  typedef enum logic [1:0] {
    RUN,
    MUL_WAIT,
    BR_WAIT,
    FLUSH
  } state_t;

  function automatic logic is_writer(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_MUL) ||
           (op == OP_INC) || (op == OP_XOR) ||
           (op == OP_CMP);
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// 16-entry pending-write scoreboard; a same-cycle set
// overrides a clear of the same bit.
module reg_scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_set,
  input  logic [3:0]  i_set_idx,
  input  logic        i_clr,
  input  logic [3:0]  i_clr_idx,
  input  logic [3:0]  i_rd_a,
  input  logic [3:0]  i_rd_b,
  output logic        o_hit_a,
  output logic        o_hit_b,
  output logic [15:0] o_mask
);

  logic [15:0] r_mask;
  logic [15:0] w_next;

  always_comb begin
    w_next = r_mask;
    if (i_clr) w_next[i_clr_idx] = 1'b0;
    if (i_set) w_next[i_set_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_mask <= '0;
    else        r_mask <= w_next;
  end

  assign o_hit_a = r_mask[i_rd_a];
  assign o_hit_b = r_mask[i_rd_b];
  assign o_mask  = r_mask;

endmodule

// File: rtl/exec_issue_ctrl.sv
// Issue controller: RAW interlock, multi-cycle MUL hold-off
// and branch-resolve / flush sequencing.
module exec_issue_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int MUL_LAT      = 3,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [7:0]  id_ctrl,
  input  logic [3:0]  id_dst,
  input  logic [3:0]  id_src1,
  input  logic [3:0]  id_src2,
  output logic        ex_valid,
  output logic [7:0]  ex_ctrl,
  output logic [3:0]  ex_dst,
  input  logic        wb_valid,
  input  logic [3:0]  wb_dst,
  input  logic        branch_taken,
  output logic        flush,
  output logic        stall,
  output logic [15:0] busy_mask
);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ex_valid;
  logic [7:0]  r_ex_ctrl;
  logic [3:0]  r_ex_dst;
  logic        r_flush;

  logic        w_busy1;
  logic        w_busy2;
  logic        w_xfer;
  logic        w_is_br;
  logic        w_is_mul;
  logic        w_set;

  assign w_is_br  = id_ctrl[BR_COND] | id_ctrl[BR_JMP];
  assign w_is_mul = (id_ctrl[2:0] == OP_MUL);
  assign id_ready = rst_n & (r_state == RUN)
                  & ~w_busy1 & ~w_busy2;
  assign w_xfer   = id_valid & id_ready;
  assign w_set    = w_xfer & is_writer(id_ctrl[2:0]);
  assign stall    = id_valid & ~id_ready;

  reg_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set     (w_set),
    .i_set_idx (id_dst),
    .i_clr     (wb_valid),
    .i_clr_idx (wb_dst),
    .i_rd_a    (id_src1),
    .i_rd_b    (id_src2),
    .o_hit_a   (w_busy1),
    .o_hit_b   (w_busy2),
    .o_mask    (busy_mask)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_cnt      <= '0;
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_dst   <= '0;
      r_flush    <= 1'b0;
    end else begin
      r_ex_valid <= w_xfer;
      if (w_xfer) begin
        r_ex_ctrl <= id_ctrl;
        r_ex_dst  <= id_dst;
      end
      unique case (r_state)
        RUN: begin
          // Branch decode takes precedence over a MUL opcode
          if (w_xfer && w_is_br) begin
            r_state <= BR_WAIT;
          end else if (w_xfer && w_is_mul && MUL_LAT > 1) begin
            r_state <= MUL_WAIT;
            r_cnt   <= 4'(MUL_LAT - 1);
          end
        end
        MUL_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        BR_WAIT: begin
          if (branch_taken) begin
            r_state <= FLUSH;
            r_cnt   <= 4'(FLUSH_CYCLES);
            r_flush <= 1'b1;
          end else begin
            r_state <= RUN;
          end
        end
        FLUSH: begin
          if (r_cnt <= 4'd1) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_flush <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign ex_valid = r_ex_valid;
  assign ex_ctrl  = r_ex_ctrl;
  assign ex_dst   = r_ex_dst;
  assign flush    = r_flush;

endmodule

// File: doc/exec_issue_ctrl.md
EXEC_ISSUE_CTRL -- requirements
Module: exec_issue_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 3: total execute-stage occupancy in cycles of a MUL op (legal 1..15).
REQ-002 Parameter FLUSH_CYCLES, default 2: cycles `flush` stays high after a taken branch (legal 1..7).
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 id_valid  in  1  decode stage presents an instruction.
REQ-006 id_ready  out  1  controller accepts the instruction this cycle.
REQ-007 id_ctrl  in  8  control word: [2:0] opcode, [3] conditional branch on flag, [7] unconditional jump.
REQ-008 id_dst / id_src1 / id_src2  in  4 each  destination and source register indices.
REQ-009 ex_valid  out  1  execute-stage issue strobe.
REQ-010 ex_ctrl  out  8  issued control word.
REQ-011 ex_dst  out  4  issued destination register.
REQ-012 wb_valid / wb_dst  in  1 / 4  writeback completed for register wb_dst.
REQ-013 branch_taken  in  1  execute-stage branch outcome, valid in the cycle after a branch issues.
REQ-014 flush  out  1  squash fetch/decode.
REQ-015 stall  out  1  equals id_valid AND NOT id_ready.
REQ-016 busy_mask  out  16  per-register pending-write bits.

Function
REQ-017 States: RUN, MUL_WAIT, BR_WAIT, FLUSH; no other state is reachable.
REQ-018 Transfer occurs when id_valid and id_ready are both high; id_ready is combinational.
REQ-019 id_ready is high only in RUN and when neither busy_mask[id_src1] nor busy_mask[id_src2] is set; WAW is not checked.
REQ-020 On transfer, ex_valid, ex_ctrl and ex_dst are registered and become visible in the next cycle; with no transfer, ex_valid is 0 in the next cycle and ex_ctrl/ex_dst hold their values.
REQ-021 Writing opcodes are 001 ADD, 010 MUL, 011 INC, 100 XOR and 110 CMP; a transfer of any of these sets busy_mask[id_dst] in the next cycle.
REQ-022 wb_valid clears busy_mask[wb_dst] in the next cycle.
REQ-023 If a transfer sets and a writeback clears the same bit in the same cycle, the set wins.
REQ-024 A transfer of MUL with MUL_LAT > 1 enters MUL_WAIT and loads a down-counter with MUL_LAT-1.
REQ-025 In MUL_WAIT, the counter decrements each cycle and the state returns to RUN when it reaches 0.
REQ-026 With MUL_LAT = 1, a MUL transfer behaves like any other writing opcode.
REQ-027 A transfer with id_ctrl[3] or id_ctrl[7] set enters BR_WAIT for exactly one cycle, and branch_taken is sampled at the end of that cycle.
REQ-028 If that sample is taken, the state moves to FLUSH with a counter of FLUSH_CYCLES; otherwise it returns to RUN.
REQ-029 In FLUSH, flush is high, id_ready is low and the counter decrements; the state returns to RUN after FLUSH_CYCLES cycles.
REQ-030 A branch control word also carrying a MUL opcode is handled by branch rules only.
REQ-031 branch_taken outside BR_WAIT is ignored.
REQ-032 busy_mask is unaffected by flush.
REQ-033 Register index 0 follows the same rules as all other indices.

Reset
REQ-034 While rst_n is low at a clock edge, the next state is RUN, counters = 0, ex_valid = 0, ex_ctrl = 0, ex_dst = 0, busy_mask = 0 and flush = 0.
REQ-035 Reset mid-MUL_WAIT, mid-BR_WAIT or mid-FLUSH aborts the operation with no residual effect.
REQ-036 id_ready is 0 in any cycle where rst_n is low.

Structure
REQ-037 Package exec_ctrl_pkg holds the opcode constants, control-bit positions (BR_COND=3, BR_JMP=7) and the state enumeration.
REQ-038 The busy-mask logic is a sub-module, reg_scoreboard: 16 bits, a set port, a clear port, set-wins priority and two combinational lookup ports.

Verification
REQ-039 Issue ADD dst=2 then XOR src1=2 with no writeback -> XOR stalls (stall=1); after wb_valid, wb_dst=2, XOR issues one cycle later.
REQ-040 Issue MUL with MUL_LAT=3 -> ex_valid for one cycle, id_ready low for exactly 2 following cycles, then high.
REQ-041 Issue jump (id_ctrl=8'h80) with branch_taken=1 in the next cycle -> flush high for 2 cycles, 0 transfers during BR_WAIT+FLUSH; repeat with branch_taken=0 -> no flush, RUN after 1 cycle.
REQ-042 Same-cycle transfer ADD dst=5 with wb_valid wb_dst=5 -> busy_mask[5]=1 afterwards.
REQ-043 Assert rst_n=0 in the second MUL_WAIT cycle with busy_mask=16'h0024 -> next cycle RUN, busy_mask=0, ex_valid=0, id_ready follows REQ-019.
